// File: rtl/accumulator_unit_if.sv
// rtl/accumulator_unit_if.sv - command handshake, AddSub link and result bundle for accumulator_unit
interface accumulator_unit_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_mode;
    logic [WIDTH-1:0] alu_sum;
    logic             alu_carry;
    logic             alu_overflow;
    logic [WIDTH-1:0] acc;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;
    logic             out_valid;
    logic [1:0]       err;

    modport master (
        output in_valid, opcode, operand, alu_sum, alu_carry, alu_overflow,
        input  in_ready, alu_a, alu_b, alu_mode, acc, flag_c, flag_v, flag_z, flag_n, out_valid, err
    );

    modport slave (
        input  in_valid, opcode, operand, alu_sum, alu_carry, alu_overflow,
        output in_ready, alu_a, alu_b, alu_mode, acc, flag_c, flag_v, flag_z, flag_n, out_valid, err
    );
endinterface

// File: rtl/accumulator_unit.sv
// rtl/accumulator_unit.sv - three-state accumulator controller driving an external combinational AddSub
module accumulator_unit #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    accumulator_unit_if.slave   bus
);
    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD   = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_CLR    = 4'd4;
    localparam logic [3:0] OP_CLRERR = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_mode_q;
    logic             c_q, v_q, z_q, n_q;
    logic [1:0]       err_q;
    logic             in_ready_q;
    logic             out_valid_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.alu_a     = acc_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_mode  = alu_mode_q;
    assign bus.acc       = acc_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_n    = n_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= '0;
            operand_q   <= '0;
            acc_q       <= '0;
            alu_b_q     <= '0;
            alu_mode_q  <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b1;
            n_q         <= 1'b0;
            err_q       <= 2'b00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    if (bus.in_valid) begin
                        op_q       <= bus.opcode;
                        operand_q  <= bus.operand;
                        // AddSub operands are presented only while the command executes
                        alu_b_q    <= bus.operand;
                        alu_mode_q <= (bus.opcode == OP_SUB);
                        in_ready_q <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    alu_b_q     <= '0;
                    alu_mode_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                    case (op_q)
                        OP_NOP: ;
                        OP_LOAD: begin
                            acc_q <= operand_q;
                            c_q   <= 1'b0;
                            v_q   <= 1'b0;
                            z_q   <= (operand_q == '0);
                            n_q   <= operand_q[WIDTH-1];
                        end
                        OP_ADD, OP_SUB: begin
                            acc_q    <= bus.alu_sum;
                            c_q      <= bus.alu_carry;
                            v_q      <= bus.alu_overflow;
                            z_q      <= (bus.alu_sum == '0);
                            n_q      <= bus.alu_sum[WIDTH-1];
                            err_q[0] <= err_q[0] | bus.alu_overflow;
                        end
                        OP_CLR: begin
                            acc_q <= '0;
                            c_q   <= 1'b0;
                            v_q   <= 1'b0;
                            z_q   <= 1'b1;
                            n_q   <= 1'b0;
                        end
                        OP_CLRERR: err_q <= 2'b00;
                        default:   err_q[1] <= 1'b1;
                    endcase
                end
                DONE: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
